// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and the iterative divider's count width.
package hilo_pkg;

    localparam int HILO_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/hilo_unit_div_iter.sv
// Unsigned restoring divider, one quotient bit per step, MSB first.
// A zero divisor loads the architectural divide-by-zero result directly.
module div_iter
    import hilo_pkg::*;
#(
    parameter int W = HILO_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         last
);

    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W:0]       shifted;
    logic [W:0]       trial;

    // Remainder stays below the divisor, so the shifted value and the trial
    // difference both fit in W+1 bits.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        shifted = {rem_q, quo_q[W-1]};
        trial   = shifted - {1'b0, dsr_q};
        if (load) begin
            dsr_d = divisor;
            cnt_d = '0;
            if (divisor == '0) begin
                quo_d = '1;
                rem_d = dividend;
            end else begin
                quo_d = dividend;
                rem_d = '0;
            end
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!trial[W]) begin
                rem_d = trial[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dsr_q <= dsr_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == CNT_W'(W - 1));

endmodule

// File: rtl/hilo_unit.sv
// HI/LO unit: MULT/MULTU through the external signed multiplier, iterative
// DIV/DIVU, and MTHI/MTLO writes into the architectural HI/LO registers.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_W,
    parameter int OP_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   rs_data,
    input  logic [WIDTH-1:0]   rt_data,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_ena,
    input  logic [2*WIDTH-1:0] mul_z,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic               mul_signed_q, mul_signed_d;
    logic               mul_ena_q, mul_ena_d;
    logic               q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic               done_q, done_d;

    op_e                op_s;
    logic               op_signed;
    logic               div_zero;
    logic [WIDTH-1:0]   div_dividend;
    logic [WIDTH-1:0]   div_quo, div_rem;
    logic               div_load, div_step, div_last;
    logic [2*WIDTH-1:0] mul_result;

    assign op_s         = op_e'(op);
    assign op_signed    = (op_s == OP_DIV);
    assign div_zero     = (rt_data == '0);
    // Divide-by-zero reports the raw dividend as remainder, not its magnitude.
    assign div_dividend = div_zero ? rs_data : magnitude(rs_data, op_signed);

    // The multiplier is signed; MULTU adds back the sign-bit weight of each operand.
    assign mul_result = mul_signed_q ? mul_z
                      : mul_z + (mul_a_q[WIDTH-1] ? {mul_b_q, {WIDTH{1'b0}}} : '0)
                              + (mul_b_q[WIDTH-1] ? {mul_a_q, {WIDTH{1'b0}}} : '0);

    div_iter #(.W(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend (div_dividend),
        .divisor  (magnitude(rt_data, op_signed)),
        .quotient (div_quo),
        .remainder(div_rem),
        .last     (div_last)
    );

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_signed_d = mul_signed_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        mul_ena_d    = 1'b0;
        done_d       = 1'b0;
        div_load     = 1'b0;
        div_step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op_s)
                        OP_MULT, OP_MULTU: begin
                            mul_a_d      = rs_data;
                            mul_b_d      = rt_data;
                            mul_signed_d = (op_s == OP_MULT);
                            mul_ena_d    = 1'b1;
                            state_d      = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            div_load = 1'b1;
                            q_neg_d  = op_signed && !div_zero && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                            r_neg_d  = op_signed && !div_zero && rs_data[WIDTH-1];
                            state_d  = div_zero ? FIX : DIV;
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                {hi_d, lo_d} = mul_result;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            DIV: begin
                div_step = 1'b1;
                if (div_last) state_d = FIX;
            end
            FIX: begin
                lo_d    = negate_if(div_quo, q_neg_q);
                hi_d    = negate_if(div_rem, r_neg_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            mul_ena_q    <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_signed_q <= mul_signed_d;
            mul_ena_q    <= mul_ena_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            done_q       <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign mul_ena = mul_ena_q;
    assign mul_a   = mul_a_q;
    assign mul_b   = mul_b_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: a transaction-level model of HI/LO compared every
// cycle, plus directed operations with hand-computed results.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data, mul_a, mul_b, hi, lo;
    logic        mul_ena, busy, done;
    logic [63:0] mul_z;

    always #5 clk = ~clk;

    // Stand-in for the CPU's combinational signed multiplier.
    assign mul_z = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});

    hilo_unit #(.WIDTH(32), .OP_W(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .mul_ena(mul_ena),
        .mul_z  (mul_z),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted op leaves the unit busy for a fixed number of
    // cycles, then the precomputed {hi,lo} lands and done follows.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;
    int          m_busy = 0;
    logic        m_done = 1'b0, m_is_mul = 1'b0;
    bit          cmp_en = 1'b0;
    longint      qa, qb, qq, qr;

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = 0; m_done = 1'b0; m_is_mul = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    {m_hi, m_lo} = m_res;
                    m_done   = 1'b1;
                    m_is_mul = 1'b0;
                end
            end else if (start) begin
                case (op)
                    3'd1: begin
                        qa = $signed(rs_data); qb = $signed(rt_data);
                        m_res = qa * qb; m_busy = 1; m_is_mul = 1'b1;
                    end
                    3'd2: begin
                        m_res = {32'b0, rs_data} * {32'b0, rt_data}; m_busy = 1; m_is_mul = 1'b1;
                    end
                    3'd3, 3'd4: begin
                        if (rt_data == 0) begin
                            m_res = {rs_data, 32'hFFFF_FFFF}; m_busy = 1;
                        end else begin
                            if (op == 3'd3) begin
                                qa = $signed(rs_data); qb = $signed(rt_data);
                            end else begin
                                qa = {32'b0, rs_data}; qb = {32'b0, rt_data};
                            end
                            qq = qa / qb; qr = qa % qb;
                            m_res = {qr[31:0], qq[31:0]}; m_busy = 33;
                        end
                    end
                    3'd5: m_hi = rs_data;
                    3'd6: m_lo = rs_data;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model hi", hi, m_hi);
            check("model lo", lo, m_lo);
            check("model busy", busy, m_busy > 0);
            check("model done", done, m_done);
            check("model mul_ena", mul_ena, (m_busy > 0) && m_is_mul);
        end
    end

    // Issue at E0, then count busy cycles and check the literal result.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int ebusy);
        int cnt = 0;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check({name, " busy cycles"}, cnt, ebusy);
        check({name, " done"}, done, ebusy > 0);
        check({name, " hi"}, hi, eh);
        check({name, " lo"}, lo, el);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
        repeat (2) @(posedge clk);
        #1 cmp_en = 1'b1;
        @(negedge clk);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset mul_ena", mul_ena, 1'b0);
        @(posedge clk); #1 reset = 1'b0;

        run_op("mult",  3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);
        check("mult mul_a hold", mul_a, 32'hFFFF_FFFE);
        check("mult mul_b hold", mul_b, 32'h0000_0003);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
        run_op("multu mixed", 3'd2, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1);
        run_op("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("div 7/-2", 3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
        run_op("divu 100/7", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_op("divu by 0", 3'd4, 32'h8000_0000, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_op("div -100 by 0", 3'd3, 32'hFFFF_FF9C, 32'h0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1);
        run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        run_op("divu big", 3'd4, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 33);
        run_op("mtlo", 3'd6, 32'h1234_5678, 32'h0, 32'h0000_FFFF, 32'h1234_5678, 0);
        run_op("mthi", 3'd5, 32'hAAAA_5555, 32'h0, 32'hAAAA_5555, 32'h1234_5678, 0);
        run_op("nop", 3'd0, 32'h1111_1111, 32'h2222_2222, 32'hAAAA_5555, 32'h1234_5678, 0);
        run_op("reserved", 3'd7, 32'h1111_1111, 32'h2222_2222, 32'hAAAA_5555, 32'h1234_5678, 0);

        // MTHI while a DIV is in flight must be dropped.
        start = 1'b1; op = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
        @(posedge clk); #1 start = 1'b0; op = 3'd0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1; op = 3'd5; rs_data = 32'hDEAD_BEEF;
        @(posedge clk); #1 start = 1'b0; op = 3'd0;
        @(negedge clk);
        check("busy mthi hi held", hi, 32'hAAAA_5555);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("busy mthi done", done, 1'b1);
        check("busy mthi hi", hi, 32'd2);
        check("busy mthi lo", lo, 32'd14);
        @(posedge clk); #1;

        // Reset during DIV iteration 10 aborts without writing HI/LO.
        start = 1'b1; op = 3'd4; rs_data = 32'h0000_1000; rt_data = 32'd3;
        @(posedge clk); #1 start = 1'b0; op = 3'd0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort mul_a", mul_a, 32'h0);
        @(negedge clk);
        check("abort no late done", done, 1'b0);
        @(posedge clk); #1;
        run_op("mult 5x6", 3'd1, 32'd5, 32'd6, 32'd0, 32'd30, 1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
